// File: rtl/ld_st_serial_tx_pkg.sv
// Shared types for the load/store serial transmitter.
// State encoding and line-level constants.
package ld_st_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/ld_st_serial_tx_if.sv
// Register-side handshake and serial line bundle.
// Ports: ld, din (to tx); ready, sout, sout_n, done (from tx).
interface ld_st_serial_tx_if #(
  parameter int WIDTH = 8
);

  logic             ld;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             sout;
  logic             sout_n;
  logic             done;

  modport master (
    output ld, din,
    input  ready, sout, sout_n, done
  );

  modport slave (
    input  ld, din,
    output ready, sout, sout_n, done
  );

endinterface

// File: rtl/ld_st_serial_tx_bit_timer.sv
// Modulo-DIV bit timer; tick marks the last clock of a bit.
// Ports: clk, clr (async high), restart (hold at 0), tick.
module ld_st_bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ld_st_serial_tx.sv
// Framed MSB-first parallel-to-serial transmitter.
// Ports: clk, clr (async high), bus (slave: ld, din, ready,
// sout, sout_n, done). Macro LD_ST_SERIAL_TX_PARITY_EN adds
// an even-parity bit between DATA and STOP.
module ld_st_serial_tx
  import ld_st_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input logic              clk,
  input logic              clr,
  ld_st_serial_tx_if.slave bus
);

  localparam int IW = $clog2(WIDTH + 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [IW-1:0]    idx, idx_n;
  logic             sout_q, sout_d;
  logic             sout_n_q;
  logic             tick;
  logic             restart;
`ifdef LD_ST_SERIAL_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // Timer sits at zero while idle so START gets a full bit.
  assign restart = (state == IDLE);

  ld_st_bit_timer #(
    .DIV(DIV)
  ) u_timer (
    .clk     (clk),
    .clr     (clr),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n   = idx;
`ifdef LD_ST_SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state)
      IDLE: begin
        if (bus.ld) begin
          state_n = START;
          shreg_n = bus.din;
          idx_n   = '0;
`ifdef LD_ST_SERIAL_TX_PARITY_EN
          par_d   = ^bus.din;
`endif
        end
      end
      START: begin
        if (tick) state_n = DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_n = {shreg[WIDTH-2:0], 1'b0};
          idx_n   = idx + IW'(1);
          if (idx == IW'(WIDTH - 1)) begin
`ifdef LD_ST_SERIAL_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef LD_ST_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (tick) state_n = STOP;
      end
`endif
      STOP: begin
        if (tick) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level is decoded from the next state so the
  // registered output lines up with the state it belongs to.
  always_comb begin
    sout_d = LINE_IDLE;
    unique case (state_n)
      START:  sout_d = START_BIT;
      DATA:   sout_d = shreg_n[WIDTH-1];
`ifdef LD_ST_SERIAL_TX_PARITY_EN
      PARITY: sout_d = par_d;
`endif
      default: sout_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      shreg    <= '0;
      idx      <= '0;
      sout_q   <= LINE_IDLE;
      sout_n_q <= ~LINE_IDLE;
`ifdef LD_ST_SERIAL_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      idx      <= idx_n;
      sout_q   <= sout_d;
      sout_n_q <= ~sout_d;
`ifdef LD_ST_SERIAL_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus.ready  = (state == IDLE);
  assign bus.done   = (state == STOP) && tick;
  assign bus.sout   = sout_q;
  assign bus.sout_n = sout_n_q;

endmodule

// File: tb/tb_ld_st_serial_tx.sv
// Directed bench for ld_st_serial_tx (8/4 and 4/1 configs).
// Works with or without LD_ST_SERIAL_TX_PARITY_EN.
module tb_ld_st_serial_tx;

`ifdef LD_ST_SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
  localparam int EXP_LEN = 44;
`else
  localparam int PAR = 0;
  localparam int EXP_LEN = 40;
`endif
  localparam int FL  = (8 + 2 + PAR) * 4;
  localparam int FL4 = (4 + 2 + PAR) * 1;

  logic clk = 1'b0;
  logic clr;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ld_st_serial_tx_if #(.WIDTH(8)) bus ();
  ld_st_serial_tx_if #(.WIDTH(4)) bus4 ();

  ld_st_serial_tx #(.WIDTH(8), .DIV(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  ld_st_serial_tx #(.WIDTH(4), .DIV(1)) dut4 (
    .clk (clk),
    .clr (clr),
    .bus (bus4)
  );

  // Expected line level in cycle k (1 = first START cycle).
  function automatic logic exp_sout(input logic [31:0] d,
                                    input int w,
                                    input int div,
                                    input int k);
    int   slot;
    logic p;
    slot = (k - 1) / div;
    if (slot == 0) return 1'b0;
    if (slot <= w) return d[w-slot];
    if (PAR == 1 && slot == w + 1) begin
      p = 1'b0;
      for (int i = 0; i < w; i++) p = p ^ d[i];
      return p;
    end
    return 1'b1;
  endfunction

  task automatic test_reset();
    clr = 1'b1;
    bus.ld = 1'b0;
    bus.din = '0;
    bus4.ld = 1'b0;
    bus4.din = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.sout !== 1'b1) begin
      n_err++;
      $display("FAIL reset_sout got %b want 1", bus.sout);
    end
    n_cmp++;
    if (bus.sout_n !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sout_n got %b want 0", bus.sout_n);
    end
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got %b want 1", bus.ready);
    end
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done got %b want 0", bus.done);
    end
    n_cmp++;
    if (bus4.sout !== 1'b1 || bus4.ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_dut4 got %b%b want 11",
               bus4.sout, bus4.ready);
    end
    clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One 8-bit frame; noise=1 pulses ld with 8'h3C mid-frame.
  task automatic test_frame(input logic [7:0] d,
                            input bit noise,
                            input string tag);
    logic e;
    bus.ld = 1'b1;
    bus.din = d;
    @(posedge clk);
    #1;
    bus.ld = 1'b0;
    bus.din = 8'h00;
    for (int k = 1; k <= FL; k++) begin
      if (noise && k >= 8 && k < FL - 4) begin
        bus.ld = 1'b1;
        bus.din = 8'h3C;
      end else begin
        bus.ld = 1'b0;
      end
      e = exp_sout({24'h0, d}, 8, 4, k);
      n_cmp++;
      if (bus.sout !== e) begin
        n_err++;
        $display("FAIL %s sout k=%0d got %b want %b",
                 tag, k, bus.sout, e);
      end
      n_cmp++;
      if (bus.sout_n !== ~e) begin
        n_err++;
        $display("FAIL %s sout_n k=%0d got %b want %b",
                 tag, k, bus.sout_n, ~e);
      end
      n_cmp++;
      if (bus.ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s ready k=%0d got %b want 0",
                 tag, k, bus.ready);
      end
      n_cmp++;
      if (bus.done !== (k == FL)) begin
        n_err++;
        $display("FAIL %s done k=%0d got %b want %b",
                 tag, k, bus.done, (k == FL));
      end
      @(posedge clk);
      #1;
    end
    bus.ld = 1'b0;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.sout !== 1'b1) begin
      n_err++;
      $display("FAIL %s idle_after got ready=%b sout=%b want 1/1",
               tag, bus.ready, bus.sout);
    end
  endtask

  task automatic test_length();
    int cnt;
    bus.ld = 1'b1;
    bus.din = 8'hA5;
    @(posedge clk);
    #1;
    bus.ld = 1'b0;
    cnt = 1;
    while (bus.done !== 1'b1 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_cmp++;
    if (cnt !== EXP_LEN) begin
      n_err++;
      $display("FAIL frame_len got %0d want %0d", cnt, EXP_LEN);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_ld();
    test_frame(8'hA5, 1'b1, "busy_ld");
    for (int k = 0; k < 60; k++) begin
      n_cmp++;
      if (bus.sout !== 1'b1 || bus.ready !== 1'b1) begin
        n_err++;
        $display("FAIL busy_ld_quiet k=%0d got sout=%b ready=%b want 1/1",
                 k, bus.sout, bus.ready);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int   m;
    logic e;
    bus.ld = 1'b1;
    bus.din = 8'hFF;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 3 * (FL + 1); k++) begin
      m = (k - 1) % (FL + 1);
      e = (m < FL) ? exp_sout(32'hFF, 8, 4, m + 1) : 1'b1;
      n_cmp++;
      if (bus.sout !== e) begin
        n_err++;
        $display("FAIL b2b sout k=%0d got %b want %b", k, bus.sout, e);
      end
      n_cmp++;
      if (bus.sout_n !== ~bus.sout) begin
        n_err++;
        $display("FAIL b2b sout_n k=%0d got %b want %b",
                 k, bus.sout_n, ~bus.sout);
      end
      n_cmp++;
      if (bus.ready !== (m == FL)) begin
        n_err++;
        $display("FAIL b2b ready k=%0d got %b want %b",
                 k, bus.ready, (m == FL));
      end
      n_cmp++;
      if (bus.done !== (m == FL - 1)) begin
        n_err++;
        $display("FAIL b2b done k=%0d got %b want %b",
                 k, bus.done, (m == FL - 1));
      end
      if (k == 3 * (FL + 1)) bus.ld = 1'b0;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.sout !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_end got ready=%b sout=%b want 1/1",
               bus.ready, bus.sout);
    end
  endtask

  task automatic test_clr_mid_data();
    logic e;
    bus.ld = 1'b1;
    bus.din = 8'h0F;
    @(posedge clk);
    #1;
    bus.ld = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      e = exp_sout(32'h0F, 8, 4, k);
      n_cmp++;
      if (bus.sout !== e) begin
        n_err++;
        $display("FAIL clr_pre sout k=%0d got %b want %b",
                 k, bus.sout, e);
      end
      if (k < 18) begin
        @(posedge clk);
        #1;
      end
    end
    clr = 1'b1;
    #1;
    n_cmp++;
    if (bus.sout !== 1'b1 || bus.sout_n !== 1'b0) begin
      n_err++;
      $display("FAIL clr_line got sout=%b sout_n=%b want 1/0",
               bus.sout, bus.sout_n);
    end
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_err++;
      $display("FAIL clr_ready got %b want 1", bus.ready);
    end
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL clr_done got %b want 0", bus.done);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;
    test_frame(8'h81, 1'b0, "after_clr");
  endtask

  task automatic test_div1();
    logic [5:0] want;
    logic       e;
    want = 6'b010011;
    bus4.ld = 1'b1;
    bus4.din = 4'b1001;
    @(posedge clk);
    #1;
    bus4.ld = 1'b0;
    for (int k = 1; k <= FL4; k++) begin
      e = exp_sout(32'h9, 4, 1, k);
      if (k <= 5) begin
        n_cmp++;
        if (e !== want[6-k]) begin
          n_err++;
          $display("FAIL div1_model k=%0d got %b want %b",
                   k, e, want[6-k]);
        end
      end
      n_cmp++;
      if (bus4.sout !== e) begin
        n_err++;
        $display("FAIL div1 sout k=%0d got %b want %b",
                 k, bus4.sout, e);
      end
      n_cmp++;
      if (bus4.done !== (k == FL4)) begin
        n_err++;
        $display("FAIL div1 done k=%0d got %b want %b",
                 k, bus4.done, (k == FL4));
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bus4.ready !== 1'b1 || bus4.sout !== 1'b1) begin
      n_err++;
      $display("FAIL div1_idle got ready=%b sout=%b want 1/1",
               bus4.ready, bus4.sout);
    end
  endtask

  task automatic test_parity();
`ifdef LD_ST_SERIAL_TX_PARITY_EN
    test_frame(8'h07, 1'b0, "par07");
    @(posedge clk);
    #1;
    test_frame(8'h03, 1'b0, "par03");
`else
    test_frame(8'h07, 1'b0, "nopar07");
`endif
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, 1'b0, "a5");
    test_length();
    test_ignore_ld();
    test_back_to_back();
    test_clr_mid_data();
    test_div1();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
